// File: rtl/sram_line_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_line_controller                                          |
// | Purpose  : Moves one cache line between the cache controller and a       |
// |            1M x 16 asynchronous SRAM as LINE_WIDTH/16 consecutive 16-bit |
// |            beats of RW_CYCLES clocks each, with per-byte write masking.  |
// | Ports    : clk, rst            clock, synchronous active-high reset      |
// |            req_*_i / req_ready_o   line request handshake                |
// |            rsp_valid_o, rsp_data_o completion pulse and read line        |
// |            ce/oe/we/lb/ub_n_o, addr_o, data_io  SRAM pins                |
// | Revision : 1.0  initial line controller                                  |
// +--------------------------------------------------------------------------+
module sram_line_controller #(
  parameter int LINE_WIDTH = 128,
  parameter int RW_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  input  logic                    req_rw_i,
  input  logic [19:0]             req_addr_i,
  input  logic [LINE_WIDTH-1:0]   req_data_i,
  input  logic [LINE_WIDTH/8-1:0] req_be_i,
  output logic                    req_ready_o,
  output logic                    rsp_valid_o,
  output logic [LINE_WIDTH-1:0]   rsp_data_o,
  output logic                    ce_n_o,
  output logic                    oe_n_o,
  output logic                    we_n_o,
  output logic                    lb_n_o,
  output logic                    ub_n_o,
  output logic [19:0]             addr_o,
  inout  wire  [15:0]             data_io
);

  localparam int BEATS  = LINE_WIDTH / 16;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = $clog2(RW_CYCLES);

  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LOAD  = WAIT_W'(RW_CYCLES - 1);
  localparam logic [19:0]           ALIGN_MASK = ~(20'(BEATS - 1));
  localparam logic [LINE_WIDTH-1:0] WORD_MASK  = LINE_WIDTH'(16'hFFFF);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  generate
    if (RW_CYCLES < 2 || LINE_WIDTH < 16 || (LINE_WIDTH % 16) != 0 ||
        (BEATS & (BEATS - 1)) != 0) begin : g_bad_params
      $error("sram_line_controller: illegal LINE_WIDTH/RW_CYCLES");
    end
  endgenerate

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [19:0]           base_q;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [LINE_WIDTH/8-1:0] be_q;
  logic [LINE_WIDTH-1:0] rline_q, rline_d;

  logic        w_beat_end;
  logic        w_last_beat;
  logic        w_accept;
  logic        w_drive;
  logic [15:0] w_wr_word;
  logic [1:0]  w_be_pair;
  logic [19:0] w_addr;

  assign w_beat_end  = (wait_q == '0);
  assign w_last_beat = (beat_q == LAST_BEAT);
  assign w_accept    = (state_q == S_IDLE) && req_valid_i;

  // Beat k lives at bit offset 16k of the line and byte-enable offset 2k;
  // shifting avoids variable part-selects.
  assign w_wr_word = 16'(wline_q >> {beat_q, 4'b0000});
  assign w_be_pair = 2'(be_q >> {beat_q, 1'b0});
  assign w_addr    = base_q + 20'(beat_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:          if (req_valid_i) state_d = req_rw_i ? S_WRITE : S_READ;
      S_READ, S_WRITE: if (w_beat_end && w_last_beat) state_d = S_RESP;
      S_RESP:          state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // Beat and wait counters; on the final beat both hold until the next accept.
  always_comb begin
    beat_d = beat_q;
    wait_d = wait_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          beat_d = '0;
          wait_d = WAIT_LOAD;
        end
      end
      S_READ, S_WRITE: begin
        if (!w_beat_end) begin
          wait_d = wait_q - 1'b1;
        end else if (!w_last_beat) begin
          beat_d = beat_q + 1'b1;
          wait_d = WAIT_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Read sample point is the last clock of each beat.
  always_comb begin
    rline_d = rline_q;
    if (state_q == S_READ && w_beat_end) begin
      rline_d = (rline_q & ~(WORD_MASK << {beat_q, 4'b0000})) |
                (LINE_WIDTH'(data_io) << {beat_q, 4'b0000});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      wait_q  <= '0;
      base_q  <= '0;
      wline_q <= '0;
      be_q    <= '0;
      rline_q <= '0;
    end else begin
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rline_q <= rline_d;
      if (w_accept) begin
        base_q  <= req_addr_i & ALIGN_MASK;
        wline_q <= req_data_i;
        be_q    <= req_be_i;
      end
    end
  end

  // Output logic: pins are Moore functions of state, beat and wait.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    ce_n_o      = 1'b1;
    oe_n_o      = 1'b1;
    we_n_o      = 1'b1;
    lb_n_o      = 1'b1;
    ub_n_o      = 1'b1;
    addr_o      = '0;
    w_drive     = 1'b0;
    case (state_q)
      S_IDLE: req_ready_o = !rst;
      S_READ: begin
        ce_n_o = 1'b0;
        oe_n_o = 1'b0;
        lb_n_o = 1'b0;
        ub_n_o = 1'b0;
        addr_o = w_addr;
      end
      S_WRITE: begin
        ce_n_o  = 1'b0;
        // WE_N rises for the last clock of the beat so data is held past it.
        we_n_o  = w_beat_end;
        lb_n_o  = ~w_be_pair[0];
        ub_n_o  = ~w_be_pair[1];
        addr_o  = w_addr;
        w_drive = 1'b1;
      end
      S_RESP:  rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data_o = rline_q;
  assign data_io    = w_drive ? w_wr_word : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_sram_line_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_line_controller                                       |
// | Purpose  : Directed self-checking bench for sram_line_controller with a  |
// |            behavioural SRAM on the default instance and address-pattern  |
// |            buses on the 16-bit/RW=3 and 256-bit instances.               |
// | Revision : 1.0  initial bench                                            |
// +--------------------------------------------------------------------------+
module tb_sram_line_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default instance (128 bits, RW=2) ----------------
  logic         req_valid = 1'b0, req_rw = 1'b0;
  logic [19:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [15:0]  req_be = '0;
  logic         req_ready, rsp_valid;
  logic [127:0] rsp_data;
  logic         ce_n, oe_n, we_n, lb_n, ub_n;
  logic [19:0]  addr;
  wire  [15:0]  data;

  sram_line_controller #(.LINE_WIDTH(128), .RW_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_rw_i(req_rw), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .ce_n_o(ce_n), .oe_n_o(oe_n), .we_n_o(we_n), .lb_n_o(lb_n), .ub_n_o(ub_n),
    .addr_o(addr), .data_io(data)
  );

  logic [15:0] mem [0:1048575];
  assign data = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[addr][7:0]  <= data[7:0];
      if (!ub_n) mem[addr][15:8] <= data[15:8];
    end
  end

  // ---------------- instance 2 (16 bits, RW=3) ----------------
  logic        req_valid2 = 1'b0, req_rw2 = 1'b0;
  logic [19:0] req_addr2 = '0;
  logic [15:0] req_data2 = '0;
  logic [1:0]  req_be2 = '0;
  logic        req_ready2, rsp_valid2;
  logic [15:0] rsp_data2;
  logic        ce2, oe2, we2, lb2, ub2;
  logic [19:0] a2;
  wire  [15:0] d2;

  sram_line_controller #(.LINE_WIDTH(16), .RW_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid2), .req_rw_i(req_rw2), .req_addr_i(req_addr2),
    .req_data_i(req_data2), .req_be_i(req_be2),
    .req_ready_o(req_ready2), .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2),
    .ce_n_o(ce2), .oe_n_o(oe2), .we_n_o(we2), .lb_n_o(lb2), .ub_n_o(ub2),
    .addr_o(a2), .data_io(d2)
  );
  assign d2 = (!ce2 && !oe2 && we2) ? {4'hA, a2[11:0]} : 16'hzzzz;

  // ---------------- instance 3 (256 bits, RW=2) ----------------
  logic         req_valid3 = 1'b0;
  logic [19:0]  req_addr3 = '0;
  logic         req_ready3, rsp_valid3;
  logic [255:0] rsp_data3;
  logic         ce3, oe3, we3, lb3, ub3;
  logic [19:0]  a3;
  wire  [15:0]  d3;

  sram_line_controller #(.LINE_WIDTH(256), .RW_CYCLES(2)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid3), .req_rw_i(1'b0), .req_addr_i(req_addr3),
    .req_data_i(256'd0), .req_be_i(32'd0),
    .req_ready_o(req_ready3), .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3),
    .ce_n_o(ce3), .oe_n_o(oe3), .we_n_o(we3), .lb_n_o(lb3), .ub_n_o(ub3),
    .addr_o(a3), .data_io(d3)
  );
  assign d3 = (!ce3 && !oe3 && we3) ? {4'hA, a3[11:0]} : 16'hzzzz;

  // ---------------- monitors ----------------
  logic [19:0] aq[$], aq2[$], aq3[$];
  logic [1:0]  bq[$];
  logic [2:0]  wq2[$];
  int          acc_q[$];
  int          bus_err = 0;
  logic        prev_wr = 1'b0, prev_we = 1'b1;
  logic [19:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!ce_n) begin
      aq.push_back(addr);
      bq.push_back({ub_n, lb_n});
    end
    if (!ce2) begin
      aq2.push_back(a2);
      wq2.push_back({we2, ub2, lb2});
    end
    if (!ce3) aq3.push_back(a3);
    if (req_valid && req_ready) acc_q.push_back(cyc);
  end

  // Bus rules: WE only inside a write beat, WE high on the last clock of
  // every beat, and never a write clock followed directly by a read clock.
  always @(negedge clk) begin
    if (!we_n && !(!ce_n && oe_n)) bus_err <= bus_err + 1;
    if (prev_wr && !prev_we && !(!ce_n && oe_n && addr == prev_addr)) bus_err <= bus_err + 1;
    if (prev_wr && !ce_n && !oe_n) bus_err <= bus_err + 1;
    prev_wr   <= !ce_n && oe_n;
    prev_we   <= we_n;
    prev_addr <= addr;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_seq(input string tag, input logic [19:0] q[$],
                           input logic [19:0] base, input int beats, input int rw);
    int bad;
    bad = 0;
    if (q.size() != beats * rw) bad = 1000 + q.size();
    else for (int i = 0; i < q.size(); i++)
      if (q[i] != base + 20'(i / rw)) bad++;
    check(tag, 256'(bad), 256'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line_req(input logic rw, input logic [19:0] a, input logic [127:0] d,
                          input logic [15:0] be, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 100) begin tick(); guard++; end
    aq.delete();
    bq.delete();
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d; req_be = be;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
  endtask

  localparam logic [127:0] LINE_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LINE_B = 128'hDEADBEEFCAFEF00D1234567855AA33CC;
  localparam logic [127:0] MASKED = 128'hFFFFFFFFFFFFFFFF0000000000000000;

  initial begin
    int lat, bad, pulses;
    logic [255:0] exp3;

    repeat (3) tick();
    check("rst_ready", 256'(req_ready), 256'd0);
    check("rst_rsp_valid", 256'(rsp_valid), 256'd0);
    check("rst_strobes", 256'({ce_n, oe_n, we_n, lb_n, ub_n}), 256'h1F);
    check("rst_addr", 256'(addr), 256'd0);
    check("rst_rsp_data", 256'(rsp_data), 256'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 256'(req_ready), 256'd1);

    // Full write then read through an unaligned address.
    line_req(1'b1, 20'h00010, LINE_A, 16'hFFFF, lat);
    check("wr_lat", 256'(lat), 256'd17);
    check_seq("wr_addr_seq", aq, 20'h00010, 8, 2);
    bad = 0;
    foreach (bq[i]) if (bq[i] != 2'b00) bad++;
    check("wr_be_full", 256'(bad), 256'd0);
    line_req(1'b0, 20'h00013, '0, '0, lat);
    check("rd_lat", 256'(lat), 256'd17);
    check("rd_data", 256'(rsp_data), 256'(LINE_A));
    check_seq("rd_unaligned_seq", aq, 20'h00010, 8, 2);

    // Byte masking: only beats 0-3 enabled.
    line_req(1'b1, 20'h00020, {128{1'b1}}, 16'hFFFF, lat);
    line_req(1'b1, 20'h00020, '0, 16'h00FF, lat);
    bad = 0;
    foreach (bq[i]) if (bq[i] != ((i < 8) ? 2'b00 : 2'b11)) bad++;
    check("mask_strobes", 256'(bad), 256'd0);
    check("rsp_data_held", 256'(rsp_data), 256'(LINE_A));
    line_req(1'b0, 20'h00020, '0, '0, lat);
    check("mask_readback", 256'(rsp_data), 256'(MASKED));

    // Top line of the address space.
    line_req(1'b1, 20'hFFFFF, LINE_B, 16'hFFFF, lat);
    check_seq("top_wr_seq", aq, 20'hFFFF8, 8, 2);
    line_req(1'b0, 20'hFFFF8, '0, '0, lat);
    check("top_readback", 256'(rsp_data), 256'(LINE_B));

    // Back-to-back reads with req_valid held high.
    bad = 0;
    while (!req_ready && bad < 100) begin tick(); bad++; end
    acc_q.delete();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 20'h00010;
    bad = 0;
    while (acc_q.size() < 2 && bad < 100) begin tick(); bad++; end
    req_valid = 1'b0;
    check("b2b_count", 256'(acc_q.size()), 256'd2);
    if (acc_q.size() >= 2) check("b2b_interval", 256'(acc_q[1] - acc_q[0]), 256'd18);
    bad = 0;
    while (!req_ready && bad < 100) begin tick(); bad++; end
    check("b2b_data", 256'(rsp_data), 256'(LINE_A));

    // Reset in the first clock of beat 3 of a read.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 20'h00020;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    check("pre_rst_addr", 256'(addr), 256'h00023);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 256'(req_ready), 256'd0);
    tick();
    check("rst_mid_strobes", 256'({ce_n, oe_n, we_n, lb_n, ub_n}), 256'h1F);
    check("rst_mid_addr", 256'(addr), 256'd0);
    check("rst_mid_rsp_data", 256'(rsp_data), 256'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 256'(req_ready), 256'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) pulses++;
      tick();
    end
    check("rst_no_rsp", 256'(pulses), 256'd0);
    line_req(1'b0, 20'h00020, '0, '0, lat);
    check("post_rst_lat", 256'(lat), 256'd17);
    check("post_rst_data", 256'(rsp_data), 256'(MASKED));

    // LINE_WIDTH=16, RW_CYCLES=3 instance.
    aq2.delete();
    req_valid2 = 1'b1; req_rw2 = 1'b0; req_addr2 = 20'h00123;
    tick();
    req_valid2 = 1'b0;
    lat = 1;
    while (!rsp_valid2 && lat < 100) begin tick(); lat++; end
    check("w16_lat", 256'(lat), 256'd4);
    check("w16_data", 256'(rsp_data2), 256'hA123);
    check_seq("w16_seq", aq2, 20'h00123, 1, 3);
    tick();
    wq2.delete();
    req_valid2 = 1'b1; req_rw2 = 1'b1; req_addr2 = 20'h00050; req_be2 = 2'b01;
    tick();
    req_valid2 = 1'b0;
    lat = 1;
    while (!rsp_valid2 && lat < 100) begin tick(); lat++; end
    check("w16_wr_lat", 256'(lat), 256'd4);
    bad = (wq2.size() == 3) ? 0 : 100;
    foreach (wq2[i]) if (wq2[i] != ((i == 2) ? 3'b110 : 3'b010)) bad++;
    check("w16_we_pattern", 256'(bad), 256'd0);

    // LINE_WIDTH=256 instance.
    aq3.delete();
    req_valid3 = 1'b1; req_addr3 = 20'h00105;
    tick();
    req_valid3 = 1'b0;
    lat = 1;
    while (!rsp_valid3 && lat < 100) begin tick(); lat++; end
    check("w256_lat", 256'(lat), 256'd33);
    exp3 = '0;
    for (int k = 0; k < 16; k++) exp3 = exp3 | (256'({4'hA, 12'h100 + 12'(k)}) << (16 * k));
    check("w256_data", rsp_data3, exp3);
    check_seq("w256_seq", aq3, 20'h00100, 16, 2);

    repeat (3) tick();
    check("bus_rules", 256'(bus_err), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
